mpu_pixel_writer: RTL and testbench

- Replaces the hard-wired test-pattern writer in the VGA top level with a real MPU-driven framebuffer write engine.
- Decodes MPU register writes into a cursor, a single-pixel write port with auto-increment, and a hardware fill engine.
- Queues pixel writes in a parametrised FIFO and drains them to the memory manager's write request interface, one per granted write slot.

---
 rtl/mpu_pixel_writer.sv | 210 +++++++++++++++++++++
 tb/tb_mpu_pixel_writer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_pixel_writer.sv
// MPU-driven framebuffer write engine: register decode, cursor with auto-increment,
// hardware fill, and a small FIFO draining into the memory manager's write port.
module mpu_pixel_writer #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned X_BITS     = 9,
    parameter int unsigned Y_BITS     = 8,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 mpuChipSelect,
    input  logic                 mpuWriteEnable,
    input  logic [2:0]           mpuRegisterSelect,
    input  logic [7:0]           mpuData,
    input  logic                 memoryWriteSlot,
    output logic                 memoryWriteRequest,
    output logic [X_BITS-1:0]    memoryXCoord,
    output logic [Y_BITS-1:0]    memoryYCoord,
    output logic [DATA_BITS-1:0] memoryWriteData,
    output logic                 busy,
    output logic                 overflow
);

    localparam int unsigned PtrBits   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntBits   = PtrBits + 1;
    localparam int unsigned EntryBits = X_BITS + Y_BITS + DATA_BITS;

    logic                 strobe_q;
    logic [X_BITS-1:0]    x_q, x_d;
    logic [Y_BITS-1:0]    y_q, y_d;
    logic [1:0]           mode_q, mode_d;
    logic [15:0]          fill_cnt_q, fill_cnt_d;
    logic                 fill_active_q, fill_active_d;
    logic [DATA_BITS-1:0] fill_val_q, fill_val_d;
    logic [16:0]          remaining_q, remaining_d;
    logic                 overflow_q, overflow_d;
    logic [PtrBits-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntBits-1:0]   count_q, count_d;
    logic [EntryBits-1:0] mem_q [FIFO_DEPTH];

    logic                 mpu_event, fifo_full, fifo_pop, fifo_push, in_range, advance;
    logic                 ovf_set, ovf_clr;
    logic [EntryBits-1:0] push_entry, head;

    // Next cursor position; X or Y wraps at its last (or any out-of-range) value and
    // carries into the other coordinate.
    function automatic logic [X_BITS+Y_BITS-1:0] advance_cursor(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y,
        input logic [1:0]        mode
    );
        logic [X_BITS-1:0] nx;
        logic [Y_BITS-1:0] ny;
        nx = x;
        ny = y;
        case (mode)
            2'b01: begin
                if (32'(x) >= WIDTH - 1) begin
                    nx = '0;
                    ny = (32'(y) >= HEIGHT - 1) ? '0 : y + Y_BITS'(1);
                end else begin
                    nx = x + X_BITS'(1);
                end
            end
            2'b10: begin
                if (32'(y) >= HEIGHT - 1) begin
                    ny = '0;
                    nx = (32'(x) >= WIDTH - 1) ? '0 : x + X_BITS'(1);
                end else begin
                    ny = y + Y_BITS'(1);
                end
            end
            default: ;
        endcase
        return {nx, ny};
    endfunction

    assign mpu_event = mpuChipSelect & mpuWriteEnable & ~strobe_q;
    assign fifo_full = (count_q == CntBits'(FIFO_DEPTH));
    assign fifo_pop  = memoryWriteSlot & (count_q != '0);
    assign in_range  = (32'(x_q) < WIDTH) && (32'(y_q) < HEIGHT);

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        mode_d        = mode_q;
        fill_cnt_d    = fill_cnt_q;
        fill_active_d = fill_active_q;
        fill_val_d    = fill_val_q;
        remaining_d   = remaining_q;
        fifo_push     = 1'b0;
        push_entry    = {x_q, y_q, fill_val_q};
        advance       = 1'b0;
        ovf_set       = 1'b0;
        ovf_clr       = 1'b0;

        if (fill_active_q) begin
            if (!fifo_full) begin
                advance     = 1'b1;
                fifo_push   = in_range;
                remaining_d = remaining_q - 17'd1;
                if (remaining_q == 17'd1) begin
                    fill_active_d = 1'b0;
                end
            end
            // The fill owns the cursor; only the count registers stay writable.
            if (mpu_event) begin
                case (mpuRegisterSelect)
                    3'd3, 3'd7: ovf_set = 1'b1;
                    3'd5:       fill_cnt_d[7:0]  = mpuData;
                    3'd6:       fill_cnt_d[15:8] = mpuData;
                    default:    ;
                endcase
            end
        end else if (mpu_event) begin
            case (mpuRegisterSelect)
                3'd0: x_d[7:0] = mpuData;
                3'd1: x_d[X_BITS-1:8] = mpuData[X_BITS-9:0];
                3'd2: y_d = mpuData[Y_BITS-1:0];
                3'd3: begin
                    advance    = 1'b1;
                    push_entry = {x_q, y_q, mpuData[DATA_BITS-1:0]};
                    if (in_range) begin
                        if (!fifo_full || fifo_pop) begin
                            fifo_push = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                end
                3'd4: begin
                    mode_d  = mpuData[1:0];
                    ovf_clr = mpuData[7];
                end
                3'd5: fill_cnt_d[7:0]  = mpuData;
                3'd6: fill_cnt_d[15:8] = mpuData;
                default: begin
                    fill_active_d = 1'b1;
                    fill_val_d    = mpuData[DATA_BITS-1:0];
                    remaining_d   = {1'b0, fill_cnt_q} + 17'd1;
                end
            endcase
        end

        if (advance) begin
            {x_d, y_d} = advance_cursor(x_q, y_q, mode_q);
        end

        overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    always_comb begin
        wr_ptr_d = fifo_push ? wr_ptr_q + PtrBits'(1) : wr_ptr_q;
        rd_ptr_d = fifo_pop  ? rd_ptr_q + PtrBits'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CntBits'(1);
            2'b01:   count_d = count_q - CntBits'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            strobe_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            mode_q        <= 2'b00;
            fill_cnt_q    <= '0;
            fill_active_q <= 1'b0;
            fill_val_q    <= '0;
            remaining_q   <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            strobe_q      <= mpuChipSelect & mpuWriteEnable;
            x_q           <= x_d;
            y_q           <= y_d;
            mode_q        <= mode_d;
            fill_cnt_q    <= fill_cnt_d;
            fill_active_q <= fill_active_d;
            fill_val_q    <= fill_val_d;
            remaining_q   <= remaining_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head               = mem_q[rd_ptr_q];
    assign memoryWriteRequest = (count_q != '0);
    assign memoryXCoord       = memoryWriteRequest ? head[EntryBits-1 -: X_BITS] : '0;
    assign memoryYCoord       = memoryWriteRequest ? head[DATA_BITS +: Y_BITS] : '0;
    assign memoryWriteData    = memoryWriteRequest ? head[DATA_BITS-1:0] : '0;
    assign busy               = fill_active_q | memoryWriteRequest;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_mpu_pixel_writer.sv
// Self-checking bench for mpu_pixel_writer: directed scenarios plus random MPU traffic,
// compared each cycle against a transaction-level reference model.
module tb_mpu_pixel_writer;

    localparam int W     = 320;
    localparam int H     = 240;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       mpuChipSelect = 1'b0;
    logic       mpuWriteEnable = 1'b0;
    logic [2:0] mpuRegisterSelect = 3'd0;
    logic [7:0] mpuData = 8'd0;
    logic       memoryWriteSlot = 1'b0;
    logic       memoryWriteRequest;
    logic [8:0] memoryXCoord;
    logic [7:0] memoryYCoord;
    logic [7:0] memoryWriteData;
    logic       busy;
    logic       overflow;

    mpu_pixel_writer dut (
        .clock              (clock),
        .resetN             (resetN),
        .mpuChipSelect      (mpuChipSelect),
        .mpuWriteEnable     (mpuWriteEnable),
        .mpuRegisterSelect  (mpuRegisterSelect),
        .mpuData            (mpuData),
        .memoryWriteSlot    (memoryWriteSlot),
        .memoryWriteRequest (memoryWriteRequest),
        .memoryXCoord       (memoryXCoord),
        .memoryYCoord       (memoryYCoord),
        .memoryWriteData    (memoryWriteData),
        .busy               (busy),
        .overflow           (overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int slot_mode = 0;  // 0 none, 1 always, 2 every 3rd cycle, 3 random

    // Reference model state (state after the most recent clock edge).
    int m_x, m_y, m_mode, m_fcnt, m_fval, m_rem;
    bit m_fill, m_ovf, m_and_prev;
    int m_q[$];
    int obs_log[$];

    function automatic int pack(int x, int y, int d);
        return (x << 16) | (y << 8) | d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_mode = 0; m_fcnt = 0; m_fval = 0; m_rem = 0;
        m_fill = 0; m_ovf = 0; m_and_prev = 0;
        m_q.delete();
    endtask

    task automatic model_advance();
        if (m_mode == 1) begin
            if (m_x >= W - 1) begin
                m_x = 0;
                m_y = (m_y >= H - 1) ? 0 : m_y + 1;
            end else m_x++;
        end else if (m_mode == 2) begin
            if (m_y >= H - 1) begin
                m_y = 0;
                m_x = (m_x >= W - 1) ? 0 : m_x + 1;
            end else m_y++;
        end
    endtask

    task automatic model_step();
        bit cs_we, ev, pop, full, do_push, set, clr, inr;
        int rs, d, entry;
        if (!resetN) begin
            model_reset();
            return;
        end
        cs_we = mpuChipSelect & mpuWriteEnable;
        ev = cs_we && !m_and_prev;
        m_and_prev = cs_we;
        pop = memoryWriteSlot && (m_q.size() > 0);
        full = (m_q.size() >= DEPTH);
        inr = (m_x < W) && (m_y < H);
        rs = int'(mpuRegisterSelect);
        d = int'(mpuData);
        do_push = 0; set = 0; clr = 0; entry = 0;
        if (m_fill) begin
            if (!full) begin
                if (inr) begin do_push = 1; entry = pack(m_x, m_y, m_fval); end
                model_advance();
                m_rem--;
                if (m_rem == 0) m_fill = 0;
            end
            if (ev) begin
                if (rs == 3 || rs == 7) set = 1;
                else if (rs == 5) m_fcnt = (m_fcnt & 'hFF00) | d;
                else if (rs == 6) m_fcnt = (m_fcnt & 'h00FF) | (d << 8);
            end
        end else if (ev) begin
            case (rs)
                0: m_x = (m_x & 'h100) | d;
                1: m_x = (m_x & 'hFF) | ((d & 1) << 8);
                2: m_y = d;
                3: begin
                    if (inr) begin
                        if (!full || pop) begin do_push = 1; entry = pack(m_x, m_y, d); end
                        else set = 1;
                    end
                    model_advance();
                end
                4: begin m_mode = d & 3; clr = (d >> 7) & 1; end
                5: m_fcnt = (m_fcnt & 'hFF00) | d;
                6: m_fcnt = (m_fcnt & 'h00FF) | (d << 8);
                default: begin m_fill = 1; m_fval = d; m_rem = m_fcnt + 1; end
            endcase
        end
        if (pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(entry);
        if (set) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic check_outputs();
        chk("req", memoryWriteRequest, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("head_x", memoryXCoord, (m_q[0] >> 16) & 'h1FF);
            chk("head_y", memoryYCoord, (m_q[0] >> 8) & 'hFF);
            chk("head_d", memoryWriteData, m_q[0] & 'hFF);
        end
        chk("busy", busy, m_fill || (m_q.size() != 0));
        chk("ovf", overflow, m_ovf);
    endtask

    // One clock: drive slot, compare against the model, log pops, advance the model.
    task automatic cycle();
        case (slot_mode)
            0: memoryWriteSlot = 1'b0;
            1: memoryWriteSlot = 1'b1;
            2: memoryWriteSlot = (cyc % 3 == 0);
            default: memoryWriteSlot = 1'($urandom_range(0, 1));
        endcase
        check_outputs();
        if (memoryWriteSlot && memoryWriteRequest)
            obs_log.push_back(pack(memoryXCoord, memoryYCoord, memoryWriteData));
        model_step();
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic mpu_write(input int rs, input int d);
        mpuChipSelect = 1'b1; mpuWriteEnable = 1'b1;
        mpuRegisterSelect = 3'(rs); mpuData = 8'(d);
        cycle();
        mpuChipSelect = 1'b0; mpuWriteEnable = 1'b0;
        cycle();
    endtask

    task automatic set_cursor(input int x, input int y);
        mpu_write(0, x & 'hFF);
        mpu_write(1, (x >> 8) & 1);
        mpu_write(2, y);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound && busy; i++) cycle();
        if (busy) chk("idle_timeout", 1, 0);
        cycle();
    endtask

    task automatic chk_log(input string tag, input int idx, input int exp);
        if (idx < obs_log.size()) chk(tag, obs_log[idx], exp);
        else chk(tag, 32'hDEAD, exp);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_req", memoryWriteRequest, 0);
        chk("rst_x", memoryXCoord, 0);
        chk("rst_y", memoryYCoord, 0);
        chk("rst_d", memoryWriteData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clock);
        resetN = 1'b1;
        cycle();

        // Basic +X writes across a line end.
        slot_mode = 1;
        mpu_write(4, 1);
        set_cursor(319, 5);
        obs_log.delete();
        mpu_write(3, 'hAA);
        mpu_write(3, 'hAA);
        mpu_write(3, 'h11);
        wait_idle(20);
        chk("t1_n", obs_log.size(), 3);
        chk_log("t1_0", 0, pack(319, 5, 'hAA));
        chk_log("t1_1", 1, pack(0, 6, 'hAA));
        chk_log("t1_2", 2, pack(1, 6, 'h11));

        // Frame-corner wrap in both increment modes.
        set_cursor(319, 239);
        obs_log.delete();
        mpu_write(3, 1);
        mpu_write(3, 2);
        mpu_write(4, 2);
        set_cursor(3, 239);
        mpu_write(3, 5);
        mpu_write(3, 6);
        wait_idle(20);
        chk("t2_n", obs_log.size(), 4);
        chk_log("t2_0", 0, pack(319, 239, 1));
        chk_log("t2_1", 1, pack(0, 0, 2));
        chk_log("t2_2", 2, pack(3, 239, 5));
        chk_log("t2_3", 3, pack(4, 0, 6));

        // Fill of 10 pixels with a slot every third cycle.
        mpu_write(4, 1);
        set_cursor(0, 0);
        mpu_write(5, 9);
        mpu_write(6, 0);
        obs_log.delete();
        slot_mode = 2;
        mpu_write(7, 'h3C);
        wait_idle(200);
        chk("t3_n", obs_log.size(), 10);
        for (int i = 0; i < 10; i++) chk_log("t3_px", i, pack(i, 0, 'h3C));

        // Overflow with no slots, then clear keeps mode.
        slot_mode = 0;
        set_cursor(0, 10);
        for (int i = 0; i < 5; i++) mpu_write(3, i);
        chk("t4_ovf_set", overflow, 1);
        chk("t4_req", memoryWriteRequest, 1);
        mpu_write(4, 'h81);
        chk("t4_ovf_clr", overflow, 0);
        obs_log.delete();
        slot_mode = 1;
        wait_idle(20);
        mpu_write(3, 'h77);
        wait_idle(20);
        chk("t4_n", obs_log.size(), 5);
        for (int i = 0; i < 4; i++) chk_log("t4_px", i, pack(i, 10, i));
        chk_log("t4_next", 4, pack(5, 10, 'h77));

        // Held strobe yields one push; out-of-range X is silently discarded.
        obs_log.delete();
        mpuChipSelect = 1'b1; mpuWriteEnable = 1'b1;
        mpuRegisterSelect = 3'd3; mpuData = 8'h55;
        for (int i = 0; i < 20; i++) cycle();
        mpuChipSelect = 1'b0; mpuWriteEnable = 1'b0;
        wait_idle(20);
        chk("t5_held_n", obs_log.size(), 1);
        chk_log("t5_held", 0, pack(6, 10, 'h55));
        obs_log.delete();
        set_cursor(400, 10);
        mpu_write(3, 'h12);
        wait_idle(20);
        chk("t5_oor_n", obs_log.size(), 0);
        chk("t5_oor_ovf", overflow, 0);

        // Random MPU traffic against the model.
        slot_mode = 3;
        for (int n = 0; n < 400; n++) begin
            int rs, d, hold, gap;
            rs = $urandom_range(0, 9);
            if (rs > 7) rs = 3;
            d = $urandom_range(0, 255);
            if (rs == 5) d = d & 15;
            if (rs == 6) d = 0;
            if (rs == 4 && $urandom_range(0, 3) != 0) d = d & 'h7F;
            hold = $urandom_range(1, 3);
            gap = $urandom_range(0, 2);
            mpuChipSelect = 1'b1; mpuWriteEnable = 1'($urandom_range(0, 7) != 0);
            mpuRegisterSelect = 3'(rs); mpuData = 8'(d);
            for (int k = 0; k < hold; k++) cycle();
            mpuChipSelect = 1'b0; mpuWriteEnable = 1'b0;
            for (int k = 0; k < gap; k++) cycle();
        end
        slot_mode = 1;
        wait_idle(500);

        // Asynchronous reset in the middle of a fill.
        slot_mode = 0;
        mpu_write(4, 'h81);
        set_cursor(0, 0);
        mpu_write(5, 20);
        mpu_write(6, 0);
        mpu_write(7, 'h99);
        for (int i = 0; i < 20 && m_q.size() < 3; i++) cycle();
        chk("t7_queued", memoryWriteRequest, 1);
        resetN = 1'b0;
        #1;
        chk("t7_req", memoryWriteRequest, 0);
        chk("t7_x", memoryXCoord, 0);
        chk("t7_y", memoryYCoord, 0);
        chk("t7_d", memoryWriteData, 0);
        chk("t7_busy", busy, 0);
        chk("t7_ovf", overflow, 0);
        model_reset();
        @(negedge clock);
        cycle();
        resetN = 1'b1;
        obs_log.delete();
        slot_mode = 1;
        for (int i = 0; i < 10; i++) cycle();
        chk("t7_after_n", obs_log.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
